// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong game-flow controller. Turns ball hit/miss events into
//               score-counter pulses, tracks remaining lives, and times the
//               respawn / game-over pauses on the frame refresh tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int LIFE_W      = 2,
    parameter int DELAY_TICKS = 120,
    parameter int TMR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              refr_tick,
    input  logic [1:0]        btn,
    input  logic              hit,
    input  logic              miss,
    output logic              d_inc,
    output logic              d_clr,
    output logic              graph_still,
    output logic              game_over,
    output logic [LIFE_W-1:0] lives,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] ONE_LIFE   = LIFE_W'(1);
    localparam logic [TMR_W-1:0]  DELAY_INIT = TMR_W'(DELAY_TICKS);

    state_t           cur_state;
    logic [TMR_W-1:0] timer;

    // Game-flow FSM: state, lives, pause timer and the registered score pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_NEWGAME;
            lives     <= LIVES_INIT;
            timer     <= '0;
            d_inc     <= 1'b0;
            d_clr     <= 1'b0;
        end else begin
            // Score pulses are single-cycle; default low every cycle
            d_inc <= 1'b0;
            d_clr <= 1'b0;
            case (cur_state)
                ST_NEWGAME: begin
                    // lives keeps whatever it held (0 after a game over) until
                    // the player actually starts the next game
                    if (btn != 2'b00) begin
                        cur_state <= ST_PLAY;
                        lives     <= LIVES_INIT;
                        d_clr     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // A miss overrides a simultaneous hit
                    if (miss) begin
                        timer <= DELAY_INIT;
                        if (lives > ONE_LIFE) begin
                            lives     <= lives - ONE_LIFE;
                            cur_state <= ST_NEWBALL;
                        end else begin
                            lives     <= '0;
                            cur_state <= ST_OVER;
                        end
                    end else if (hit) begin
                        d_inc <= 1'b1;
                    end
                end
                ST_NEWBALL: begin
                    // Buttons only count once the respawn pause has expired
                    if (timer == '0) begin
                        if (btn != 2'b00) begin
                            cur_state <= ST_PLAY;
                        end
                    end else if (refr_tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_OVER: begin
                    // Final score stays on display; return automatically
                    if (timer == '0) begin
                        cur_state <= ST_NEWGAME;
                    end else if (refr_tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    cur_state <= ST_NEWGAME;
                end
            endcase
        end
    end

    // Status decode straight from the state register
    always_comb begin
        state       = cur_state;
        graph_still = (cur_state != ST_PLAY);
        game_over   = (cur_state == ST_OVER);
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Scoreboard bench for pong_game_ctrl (LIVES=3, DELAY_TICKS=4).
//               A behavioural game model predicts every cycle's outputs; the
//               prediction is queued when stimulus is driven and compared
//               once the DUT has clocked it in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int LIVES       = 3;
    localparam int LIFE_W      = 2;
    localparam int DELAY_TICKS = 4;
    localparam int TMR_W       = 8;

    localparam logic [1:0] S_NEWGAME = 2'b00;
    localparam logic [1:0] S_PLAY    = 2'b01;
    localparam logic [1:0] S_NEWBALL = 2'b10;
    localparam logic [1:0] S_OVER    = 2'b11;

    logic              clk;
    logic              reset;
    logic              refr_tick;
    logic [1:0]        btn;
    logic              hit;
    logic              miss;
    logic              d_inc;
    logic              d_clr;
    logic              graph_still;
    logic              game_over;
    logic [LIFE_W-1:0] lives;
    logic [1:0]        state;

    int checks;
    int errors;

    typedef struct {
        logic [1:0]       st;
        logic [1:0]       lv;
        logic [TMR_W-1:0] tmr;
        logic             inc;
        logic             clr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [1:0]       m_st;
    logic [1:0]       m_lv;
    logic [TMR_W-1:0] m_tmr;
    logic             m_inc;
    logic             m_clr;

    pong_game_ctrl #(
        .LIVES       (LIVES),
        .LIFE_W      (LIFE_W),
        .DELAY_TICKS (DELAY_TICKS),
        .TMR_W       (TMR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refr_tick   (refr_tick),
        .btn         (btn),
        .hit         (hit),
        .miss        (miss),
        .d_inc       (d_inc),
        .d_clr       (d_clr),
        .graph_still (graph_still),
        .game_over   (game_over),
        .lives       (lives),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given the inputs about to be sampled
    task automatic model_step(input logic r, input logic [1:0] b, input logic h,
                              input logic m, input logic t);
        logic [1:0]       n_st;
        logic [1:0]       n_lv;
        logic [TMR_W-1:0] n_tmr;
        n_st  = m_st;
        n_lv  = m_lv;
        n_tmr = m_tmr;
        if (r) begin
            m_st  = S_NEWGAME;
            m_lv  = 2'(LIVES);
            m_tmr = '0;
            m_inc = 1'b0;
            m_clr = 1'b0;
        end else begin
            m_inc = (m_st == S_PLAY) && h && !m;
            m_clr = (m_st == S_NEWGAME) && (b != 2'b00);
            case (m_st)
                S_NEWGAME: if (b != 2'b00) begin n_st = S_PLAY; n_lv = 2'(LIVES); end
                S_PLAY: if (m) begin
                    n_tmr = TMR_W'(DELAY_TICKS);
                    if (m_lv > 2'd1) begin n_lv = m_lv - 2'd1; n_st = S_NEWBALL; end
                    else begin n_lv = 2'd0; n_st = S_OVER; end
                end
                S_NEWBALL: if (m_tmr == 0) begin if (b != 2'b00) n_st = S_PLAY; end
                           else if (t) n_tmr = m_tmr - 1'b1;
                default:   if (m_tmr == 0) n_st = S_NEWGAME;
                           else if (t) n_tmr = m_tmr - 1'b1;
            endcase
            m_st  = n_st;
            m_lv  = n_lv;
            m_tmr = n_tmr;
        end
    endtask

    // Drive one cycle of stimulus, queue the prediction, then compare
    task automatic step(input logic r, input logic [1:0] b, input logic h,
                        input logic m, input logic t);
        exp_t e;
        exp_t got_e;
        reset     = r;
        btn       = b;
        hit       = h;
        miss      = m;
        refr_tick = t;
        model_step(r, b, h, m, t);
        e.st = m_st; e.lv = m_lv; e.tmr = m_tmr; e.inc = m_inc; e.clr = m_clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            got_e = exp_q.pop_front();
            check("state",       32'(state),       32'(got_e.st));
            check("lives",       32'(lives),       32'(got_e.lv));
            check("timer",       32'(dut.timer),   32'(got_e.tmr));
            check("d_inc",       32'(d_inc),       32'(got_e.inc));
            check("d_clr",       32'(d_clr),       32'(got_e.clr));
            check("graph_still", 32'(graph_still), 32'(got_e.st != S_PLAY));
            check("game_over",   32'(game_over),   32'(got_e.st == S_OVER));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Complete a respawn pause: ticks (with btn held to show it is ignored),
    // then release and press a button to resume play
    task automatic respawn();
        for (int i = 0; i < DELAY_TICKS; i++) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_st = S_NEWGAME; m_lv = 2'(LIVES); m_tmr = '0; m_inc = 1'b0; m_clr = 1'b0;
        reset = 1'b1; btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        // Idle NEWGAME with stray hit/miss pulses
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

        // Start game: d_clr, PLAY, lives 3
        step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Five hits spaced three cycles apart, buttons ignored
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
            idle(2);
        end

        // Simultaneous hit + miss: miss wins
        step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        // Stray events during NEWBALL
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        respawn();
        idle(1);

        // Miss down to one life, then the final miss into OVER
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        respawn();
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

        // Stray events and non-tick cycles during OVER
        step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DELAY_TICKS; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
            step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        // Zero observed -> NEWGAME, lives still 0
        idle(2);
        step(1'b0, 2'b00, 1'b1, 1'b1, 1'b1);

        // New game reloads lives
        step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset mid-NEWBALL with timer = 2
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
